// File: rtl/iob_plic_claim_master_pkg.sv
// Shared definitions for the PLIC claim/complete initiator.
// This covers the FSM state encoding and the spurious-ID rule.
package iob_plic_claim_master_pkg;

  localparam int STATE_W  = 3;
  localparam int MAX_ID_W = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE          = 3'd0,
    ST_CLAIM_REQ     = 3'd1,
    ST_CLAIM_WAIT    = 3'd2,
    ST_DELIVER       = 3'd3,
    ST_SERVICE       = 3'd4,
    ST_COMPLETE_REQ  = 3'd5,
    ST_COMPLETE_WAIT = 3'd6
  } state_t;

  // A claim that returns ID 0 means the PLIC had nothing pending for us.
  function automatic logic is_spurious_id(input logic [MAX_ID_W-1:0] id_bits);
    return (id_bits == {MAX_ID_W{1'b0}});
  endfunction

endpackage

// File: rtl/iob_plic_claim_master_if.sv
// IOb request/response bus between the claim initiator and the PLIC target registers.
interface iob_plic_claim_master_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic                valid;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (
    output valid, address, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/iob_plic_cm_timeout.sv
// Loadable down-counter used to bound how long the initiator waits for IOb ready.
// Loaded while a request is issued, so the limit hits on wait cycle 2**W-1.
module iob_plic_cm_timeout #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [W-1:0] LOAD_VAL = W'((2 ** W) - 2);

  logic [W-1:0] r_cnt;

  // Count down while waiting; park at zero until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_run && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_run && (r_cnt == {W{1'b0}});

endmodule

// File: rtl/iob_plic_claim_master.sv
// IOb initiator for one PLIC target: claims an interrupt ID on irq and hands it to a consumer.
// It then writes the same ID back once the consumer signals done.
module iob_plic_claim_master
  import iob_plic_claim_master_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 32,
  parameter int              ID_W       = 7,
  parameter logic [ADDR_W-1:0] CLAIM_ADDR = {ADDR_W{1'b0}},
  parameter int              TIMEOUT_W  = 8,
  parameter int              CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_irq,
  iob_plic_claim_master_if.master iob,
  output logic                   o_id_valid,
  output logic [ID_W-1:0]        o_id,
  input  logic                   i_id_ready,
  input  logic                   i_done,
  output logic                   o_busy,
  output logic                   o_err,
  input  logic                   i_err_clr,
  output logic [CNT_W-1:0]       o_claim_cnt,
  output logic [CNT_W-1:0]       o_spur_cnt
);

  state_t              r_state;
  state_t              w_next;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [ID_W-1:0]     r_id;
  logic                r_id_valid;
  logic                r_busy;
  logic                r_err;
  logic [CNT_W-1:0]    r_claim_cnt;
  logic [CNT_W-1:0]    r_spur_cnt;

  logic w_spurious;
  logic w_expired;
  logic w_tmo_load;
  logic w_tmo_run;
  logic w_capture;
  logic w_spur_hit;
  logic w_claim_done;
  logic w_timeout;
  logic w_unused;

  assign w_spurious = is_spurious_id(MAX_ID_W'(iob.rdata[ID_W-1:0]));
  assign w_tmo_load = (r_state == ST_CLAIM_REQ) || (r_state == ST_COMPLETE_REQ);
  assign w_tmo_run  = (r_state == ST_CLAIM_WAIT) || (r_state == ST_COMPLETE_WAIT);
  assign w_unused   = ^iob.rdata;

  iob_plic_cm_timeout #(
    .W (TIMEOUT_W)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmo_load),
    .i_run     (w_tmo_run),
    .o_expired (w_expired)
  );

  // Next-state decode plus the single-cycle events that update counters and flags.
  always_comb begin
    w_next       = r_state;
    w_capture    = 1'b0;
    w_spur_hit   = 1'b0;
    w_claim_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && i_irq) w_next = ST_CLAIM_REQ;
        else               w_next = ST_IDLE;
      end
      ST_CLAIM_REQ: w_next = ST_CLAIM_WAIT;
      ST_CLAIM_WAIT: begin
        if (iob.ready) begin
          if (w_spurious) begin
            w_spur_hit = 1'b1;
            w_next     = ST_IDLE;
          end else begin
            w_capture = 1'b1;
            w_next    = ST_DELIVER;
          end
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_CLAIM_WAIT;
        end
      end
      ST_DELIVER: begin
        if (i_id_ready) w_next = ST_SERVICE;
        else            w_next = ST_DELIVER;
      end
      ST_SERVICE: begin
        if (i_done) w_next = ST_COMPLETE_REQ;
        else        w_next = ST_SERVICE;
      end
      ST_COMPLETE_REQ: w_next = ST_COMPLETE_WAIT;
      ST_COMPLETE_WAIT: begin
        if (iob.ready) begin
          w_claim_done = 1'b1;
          w_next       = ST_IDLE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next = ST_COMPLETE_WAIT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // IOb request: valid pulses one cycle after a *_REQ state, payload held until the next request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_address <= {ADDR_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
      r_wstrb   <= {(DATA_W/8){1'b0}};
    end else if (r_state == ST_CLAIM_REQ) begin
      r_valid   <= 1'b1;
      r_address <= CLAIM_ADDR;
      r_wdata   <= {DATA_W{1'b0}};
      r_wstrb   <= {(DATA_W/8){1'b0}};
    end else if (r_state == ST_COMPLETE_REQ) begin
      r_valid   <= 1'b1;
      r_address <= CLAIM_ADDR;
      r_wdata   <= DATA_W'(r_id);
      r_wstrb   <= {(DATA_W/8){1'b1}};
    end else begin
      r_valid   <= 1'b0;
      r_address <= r_address;
      r_wdata   <= r_wdata;
      r_wstrb   <= r_wstrb;
    end
  end

  // Claimed ID and stream/busy flags, aligned with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id       <= {ID_W{1'b0}};
      r_id_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_id       <= w_capture ? iob.rdata[ID_W-1:0] : r_id;
      r_id_valid <= (w_next == ST_DELIVER);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  // Sticky timeout flag; a fresh timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (i_err_clr) r_err <= 1'b0;
    else                r_err <= r_err;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_claim_cnt <= {CNT_W{1'b0}};
      r_spur_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_claim_done && (r_claim_cnt != {CNT_W{1'b1}})) r_claim_cnt <= r_claim_cnt + CNT_W'(1);
      else                                                 r_claim_cnt <= r_claim_cnt;
      if (w_spur_hit && (r_spur_cnt != {CNT_W{1'b1}}))    r_spur_cnt  <= r_spur_cnt + CNT_W'(1);
      else                                                 r_spur_cnt  <= r_spur_cnt;
    end
  end

  assign iob.valid   = r_valid;
  assign iob.address = r_address;
  assign iob.wdata   = r_wdata;
  assign iob.wstrb   = r_wstrb;
  assign o_id        = r_id;
  assign o_id_valid  = r_id_valid;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
  assign o_claim_cnt = r_claim_cnt;
  assign o_spur_cnt  = r_spur_cnt;

endmodule

// File: tb/tb_iob_plic_claim_master.sv
// Scoreboard bench for iob_plic_claim_master: an IOb target model answers claims.
// Expected bus transfers and delivered IDs are queued up front and matched as the DUT produces them.
module tb_iob_plic_claim_master;

  localparam int               ADDR_W     = 16;
  localparam int               DATA_W     = 32;
  localparam int               ID_W       = 7;
  localparam logic [15:0]      CLAIM_ADDR = 16'h0204;
  localparam int               TIMEOUT_W  = 4;
  localparam int               CNT_W      = 2;

  logic clk, rst, en, irq, id_ready, done, err_clr;
  logic             id_valid;
  logic [ID_W-1:0]  id;
  logic             busy, err;
  logic [CNT_W-1:0] claim_cnt, spur_cnt;

  iob_plic_claim_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) iob ();

  iob_plic_claim_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CLAIM_ADDR(CLAIM_ADDR),
    .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_irq(irq), .iob(iob),
    .o_id_valid(id_valid), .o_id(id), .i_id_ready(id_ready), .i_done(done),
    .o_busy(busy), .o_err(err), .i_err_clr(err_clr),
    .o_claim_cnt(claim_cnt), .o_spur_cnt(spur_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [51:0]    txn_q[$];   // {address, wdata, wstrb}
  logic [ID_W-1:0] id_q[$];
  logic [31:0]    rsp_q[$];
  int             rsp_delay = 1;
  logic           drop_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // IOb target model: answers each request rsp_delay cycles later, ready for one cycle.
  initial begin
    int cnt;
    logic [31:0] cur;
    cnt = 0;
    cur = 32'h0;
    iob.ready = 1'b0;
    iob.rdata = 32'h0000_007F;
    forever begin
      @(negedge clk);
      iob.ready = 1'b0;
      iob.rdata = 32'h0000_007F;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            iob.ready = 1'b1;
            iob.rdata = cur;
          end
        end
        if (iob.valid && !drop_ready) begin
          cnt = rsp_delay;
          if (iob.wstrb == 4'h0) cur = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
          else                   cur = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: match bus requests and ID handshakes against the scoreboard queues.
  initial begin
    logic [51:0] t;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (iob.valid) begin
          if (txn_q.size() == 0) begin
            chk("txn_unexpected", {iob.address, iob.wstrb}, 64'h0);
          end else begin
            t = txn_q.pop_front();
            chk("txn_addr",  iob.address, t[51:36]);
            chk("txn_wdata", iob.wdata,   t[35:4]);
            chk("txn_wstrb", iob.wstrb,   t[3:0]);
          end
        end
        if (id_valid && id_ready) begin
          if (id_q.size() == 0) chk("id_unexpected", id, 64'hFFFF);
          else                  chk("id_value", id, id_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic run_claim(input logic [31:0] rsp, input int dly);
    int k;
    logic [ID_W-1:0] eid;
    eid = rsp[ID_W-1:0];
    rsp_q.push_back(rsp);
    rsp_delay = dly;
    txn_q.push_back({CLAIM_ADDR, 32'h0, 4'h0});
    id_q.push_back(eid);
    id_ready = 1'b1;
    irq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!iob.valid && k < 20);
    chk("claim_latency", k, 2);
    irq = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!id_valid && k < 40);
    chk("id_latency", k, dly + 1);
    repeat (3) @(negedge clk);
    txn_q.push_back({CLAIM_ADDR, 32'(eid), 4'hF});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_idle(40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; irq = 1'b0; id_ready = 1'b0; done = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {iob.valid, iob.address, iob.wdata, iob.wstrb}, 64'h0);
    chk("rst_ctl", {id_valid, id, busy, err, claim_cnt, spur_cnt}, 64'h0);
    rst = 1'b0;
    en = 1'b1;
    @(negedge clk);

    // Basic claim/complete with id 5.
    run_claim(32'h0000_0005, 1);
    chk("s1_claim_cnt", claim_cnt, 2'd1);
    chk("s1_spur_cnt", spur_cnt, 2'd0);

    // Spurious: low ID bits zero, upper bits set and ignored.
    rsp_q.push_back(32'hFFFF_FF80);
    rsp_delay = 1;
    txn_q.push_back({CLAIM_ADDR, 32'h0, 4'h0});
    id_ready = 1'b1;
    irq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!iob.valid && k < 20);
    irq = 1'b0;
    wait_idle(20);
    chk("s2_spur_cnt", spur_cnt, 2'd1);
    chk("s2_claim_cnt", claim_cnt, 2'd1);
    chk("s2_txn_left", txn_q.size(), 0);

    // Backpressure: id held, early done and done alongside id_ready both ignored.
    rsp_q.push_back(32'h1234_5683);
    txn_q.push_back({CLAIM_ADDR, 32'h0, 4'h0});
    id_q.push_back(7'h03);
    id_ready = 1'b0;
    irq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!id_valid && k < 20);
    irq = 1'b0;
    for (int c = 0; c < 10; c++) begin
      done = (c == 4);
      @(negedge clk);
      chk("s3_id_held", {id_valid, id}, {1'b1, 7'h03});
    end
    done = 1'b0;
    id_ready = 1'b1;
    done = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk("s3_in_service", {busy, id_valid}, 2'b10);
    txn_q.push_back({CLAIM_ADDR, 32'h0000_0003, 4'hF});
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_idle(20);
    chk("s3_claim_cnt", claim_cnt, 2'd2);

    // Ready on the timeout limit cycle still completes; upper rdata bits ignored.
    run_claim(32'hABCD_0091, 14);
    chk("s4_claim_cnt", claim_cnt, 2'd3);
    chk("s4_err", err, 1'b0);

    // Timeout: no ready ever returned.
    drop_ready = 1'b1;
    txn_q.push_back({CLAIM_ADDR, 32'h0, 4'h0});
    irq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!iob.valid && k < 20);
    irq = 1'b0;
    repeat (14) @(negedge clk);
    chk("s5_before_limit", {busy, err}, 2'b10);
    @(negedge clk);
    chk("s5_after_limit", {busy, err}, 2'b01);
    chk("s5_counters", {claim_cnt, spur_cnt}, {2'd3, 2'd1});
    repeat (3) @(negedge clk);
    chk("s5_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("s5_err_clr", err, 1'b0);
    drop_ready = 1'b0;

    // Reset while in SERVICE with id 9.
    rsp_q.push_back(32'h0000_0009);
    txn_q.push_back({CLAIM_ADDR, 32'h0, 4'h0});
    id_q.push_back(7'h09);
    id_ready = 1'b1;
    irq = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!id_valid && k < 20);
    irq = 1'b0;
    @(negedge clk);
    chk("s6_in_service", {busy, id}, {1'b1, 7'h09});
    rst = 1'b1;
    #1;
    chk("s6_rst_bus", {iob.valid, iob.address, iob.wdata, iob.wstrb}, 64'h0);
    chk("s6_rst_ctl", {id_valid, id, busy, err, claim_cnt, spur_cnt}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (20) @(negedge clk);
    chk("s6_no_complete", {busy, 8'(txn_q.size())}, 9'h0);

    // en=0 blocks claims, then saturation of claim_cnt.
    en = 1'b0;
    irq = 1'b1;
    repeat (10) @(negedge clk);
    chk("s7_en_block", busy, 1'b0);
    irq = 1'b0;
    en = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      run_claim(32'h0000_0010 + 32'(i), 1);
      chk("s7_claim_sat", claim_cnt, (i > 3) ? 2'd3 : 2'(i));
    end
    chk("end_txn_left", txn_q.size(), 0);
    chk("end_id_left", id_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
